neuron_layer_one_fsm: RTL and testbench
=======================================

NEURON_LAYER_ONE_FSM -- requirements
Module: neuron_layer_one_fsm

Interface
REQ-001 SHALL have parameter M0, default 784, meaning number of input pixels per image.
REQ-002 SHALL have parameter M1, default 16, meaning number of layer-1 neurons.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning shared byte-memory address width.
REQ-004 SHALL have port clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  begin inference; sampled only in IDLE.
REQ-007 SHALL have port data_from_mem  input  8  byte read from shared memory.
REQ-008 SHALL have port mem_addr  output  ADDR_WIDTH  registered read address.
REQ-009 SHALL have port layer1_outputs  output  signed 26 x [0:M1-1]  per-neuron result, Q14.12, post-ReLU.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse; drives the layer-2 start.

Function
REQ-012 SHALL use the memory map: image at 0..M0-1, bias1[n] at 784+n, weight1[n][i] at 800+n*M0+i; highest address used is 13343.
REQ-013 SHALL treat memory read latency as two edges: data_from_mem is sampled on the second rising edge after the edge that updates mem_addr.
REQ-014 SHALL implement the states IDLE, BIAS_ADDR, BIAS_WAIT1, BIAS_WAIT2, PIX_ADDR, PIX_WAIT, PIX_LATCH, W_WAIT, W_LATCH, MAC, STORE and DONE.
REQ-015 SHALL in IDLE, when start=1: clear n and i, and go to BIAS_ADDR; otherwise hold.
REQ-016 SHALL in BIAS_ADDR drive mem_addr<=784+n, then go to BIAS_WAIT1, then BIAS_WAIT2.
REQ-017 SHALL in BIAS_WAIT2 load acc<=sign-extended bias byte (Q4.4) <<<8, clear i, and go to PIX_ADDR.
REQ-018 SHALL in PIX_ADDR drive mem_addr<=i, then go to PIX_WAIT.
REQ-019 SHALL in PIX_LATCH capture the pixel byte as unsigned Q0.8, drive mem_addr<=800+n*M0+i, and go to W_WAIT.
REQ-020 SHALL in W_LATCH capture the weight byte as signed Q3.5.
REQ-021 SHALL in MAC add to the 32-bit signed acc: (zero-extended pixel x signed weight) >>>1 (arithmetic shift, Q.12).
REQ-022 SHALL leave MAC for STORE if i==M0-1; otherwise increment i and return to PIX_ADDR.
REQ-023 SHALL in STORE write layer1_outputs[n]<=0 if acc<0, else acc[25:0]; the worst-case magnitude of 12,727,040 fits in 26 bits, so no clamp is needed.
REQ-024 SHALL leave STORE for DONE if n==M1-1; otherwise increment n and go to BIAS_ADDR.
REQ-025 SHALL in DONE hold done=1 for exactly that one cycle, then go to IDLE.
REQ-026 SHALL take 4708 cycles per neuron: 3 + 6*M0 + 1.
REQ-027 SHALL raise done exactly 75329 edges after the edge that samples start.
REQ-028 SHALL ignore start outside IDLE, including start held high or pulsed mid-run.
REQ-029 SHALL allow a start in the cycle after DONE to begin a new run.
REQ-030 SHALL hold layer1_outputs stable from DONE until the STORE of the same index in the next run, so layer 2 may copy them at leisure.
REQ-031 SHALL keep mem_addr unchanged in all states that do not explicitly drive it.

Reset
REQ-032 SHALL, on rst=1 at a rising edge in any state, force state=IDLE, mem_addr=0, done=0, busy=0, n=i=0, acc=0, pixel/weight registers=0, and all layer1_outputs=0.
REQ-033 SHALL abandon an in-progress run on reset and produce no done pulse for it.
REQ-034 SHALL treat rst as taking priority over start in the same cycle.

Verification
REQ-035 SHALL cover: rst high 2 cycles -> all outputs 0, mem_addr=0, busy=0, done=0.
REQ-036 SHALL cover: all pixels 0, bias1[n]=(n-8)*16 -> layer1_outputs[n]=max(0,n-8)*4096; done after 75329 edges; first mem_addr sequence 784,0,800,1,801.
REQ-037 SHALL cover: all pixels 255, all weights 0x01, biases 0 -> every output = 784*127 = 99568.
REQ-038 SHALL cover: pixels 255, weights 0x80, biases 0x7F -> every output 0 (ReLU); with weights 0x7F, biases 0x7F -> every output 12,727,040.
REQ-039 SHALL cover: start re-pulsed at cycle 1000 and held high through the run -> single done pulse at 75329; a second start after done -> an identical second run with outputs rewritten.
REQ-040 SHALL cover: rst asserted during neuron 5 -> IDLE next edge, outputs 0, no done; subsequent start -> full correct run.

Source files
------------

// File: rtl/neuron_layer_one_fsm.sv
// Layer-1 dense neuron engine: streams image, bias and weight bytes from a shared
// byte memory, accumulates per neuron in Q.12, applies ReLU and latches each result.
//
// state      | meaning
// IDLE       | waiting for start
// BIAS_ADDR  | issue bias address for neuron n
// BIAS_WAIT1 | bias read in flight
// BIAS_WAIT2 | bias byte arrives, seed accumulator
// PIX_ADDR   | issue pixel address i
// PIX_WAIT   | pixel read in flight
// PIX_LATCH  | capture pixel, issue weight address
// W_WAIT     | weight read in flight
// W_LATCH    | capture weight
// MAC        | accumulate pixel x weight
// STORE      | ReLU and latch result for neuron n
// DONE       | run complete, done pulse follows
module neuron_layer_one_fsm #(
    parameter int M0         = 784,
    parameter int M1         = 16,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            data_from_mem,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic signed [25:0]    layer1_outputs [0:M1-1],
    output logic                  busy,
    output logic                  done
);

    localparam int NW = (M1 > 1) ? $clog2(M1) : 1;
    localparam int IW = (M0 > 1) ? $clog2(M0) : 1;

    typedef enum logic [3:0] {
        IDLE, BIAS_ADDR, BIAS_WAIT1, BIAS_WAIT2, PIX_ADDR, PIX_WAIT,
        PIX_LATCH, W_WAIT, W_LATCH, MAC, STORE, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NW-1:0]           n_q, n_d;
    logic [IW-1:0]           i_q, i_d;
    logic signed [31:0]      acc_q, acc_d;
    logic [7:0]              pix_q, pix_d;
    logic signed [7:0]       wgt_q, wgt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    done_q, done_d;
    logic signed [25:0]      out_q [0:M1-1];
    logic signed [25:0]      out_d [0:M1-1];
    logic signed [16:0]      prod;
    logic signed [31:0]      prod_ext;

    // Pixel is unsigned, so widen it with a zero sign bit before the signed multiply.
    assign prod     = $signed({1'b0, pix_q}) * wgt_q;
    assign prod_ext = {{15{prod[16]}}, prod};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        acc_d   = acc_q;
        pix_d   = pix_q;
        wgt_d   = wgt_q;
        addr_d  = addr_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = '0;
                    i_d     = '0;
                    state_d = BIAS_ADDR;
                end
            end
            BIAS_ADDR: begin
                addr_d  = ADDR_WIDTH'(M0 + int'(n_q));
                state_d = BIAS_WAIT1;
            end
            BIAS_WAIT1: state_d = BIAS_WAIT2;
            BIAS_WAIT2: begin
                acc_d   = {{16{data_from_mem[7]}}, data_from_mem, 8'h00};
                i_d     = '0;
                state_d = PIX_ADDR;
            end
            PIX_ADDR: begin
                addr_d  = ADDR_WIDTH'(int'(i_q));
                state_d = PIX_WAIT;
            end
            PIX_WAIT: state_d = PIX_LATCH;
            PIX_LATCH: begin
                pix_d   = data_from_mem;
                addr_d  = ADDR_WIDTH'(M0 + M1 + int'(n_q) * M0 + int'(i_q));
                state_d = W_WAIT;
            end
            W_WAIT: state_d = W_LATCH;
            W_LATCH: begin
                wgt_d   = $signed(data_from_mem);
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + (prod_ext >>> 1);
                if (i_q == IW'(M0 - 1)) begin
                    state_d = STORE;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = PIX_ADDR;
                end
            end
            STORE: begin
                out_d[n_q] = acc_q[31] ? '0 : $signed(acc_q[25:0]);
                if (n_q == NW'(M1 - 1)) begin
                    state_d = DONE;
                end else begin
                    n_d     = n_q + NW'(1);
                    state_d = BIAS_ADDR;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            pix_q   <= '0;
            wgt_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < M1; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            pix_q   <= pix_d;
            wgt_q   <= wgt_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign mem_addr       = addr_q;
    assign layer1_outputs = out_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_neuron_layer_one_fsm.sv
// Bench for neuron_layer_one_fsm: small geometry, byte memory model with a registered
// read, and an arithmetic reference computed straight from the memory contents.
module tb_neuron_layer_one_fsm;

    localparam int M0        = 4;
    localparam int M1        = 16;
    localparam int AW        = 14;
    localparam int RUN_EDGES = M1 * (6 * M0 + 4) + 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [7:0]           data_from_mem;
    logic [AW-1:0]        mem_addr;
    logic signed [25:0]   layer1_outputs [0:M1-1];
    logic                 busy;
    logic                 done;

    logic [7:0]           mem [0:255];
    logic [7:0]           rd_q;
    logic [AW-1:0]        addr_log [$];
    logic [AW-1:0]        prev_addr;
    bit                   log_en;
    int                   exp_out [M1];
    int                   pass_cnt;
    int                   total_cnt;

    neuron_layer_one_fsm #(.M0(M0), .M1(M1), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .data_from_mem  (data_from_mem),
        .mem_addr       (mem_addr),
        .layer1_outputs (layer1_outputs),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= mem[mem_addr[7:0]];
    assign data_from_mem = rd_q;

    always @(posedge clk) begin
        #1;
        if (log_en && mem_addr !== prev_addr) addr_log.push_back(mem_addr);
        prev_addr = mem_addr;
    end

    // Neuron n = bias<<8 + sum over pixels of floor(pixel*weight/2), then ReLU.
    function automatic void compute_model();
        for (int n = 0; n < M1; n++) begin
            int acc;
            acc = int'($signed(mem[M0 + n])) * 256;
            for (int i = 0; i < M0; i++) begin
                int p;
                int w;
                p = int'(mem[i]);
                w = int'($signed(mem[M0 + M1 + n * M0 + i]));
                acc += (p * w) >>> 1;
            end
            exp_out[n] = (acc < 0) ? 0 : acc;
        end
    endfunction

    task automatic randomize_mem();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    endtask

    task automatic do_run(input int hold_at, output int done_edge);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_edge = -1;
        for (int e = 1; e <= RUN_EDGES + 50; e++) begin
            @(posedge clk);
            #1;
            if (e == hold_at) start = 1'b1;
            if (done === 1'b1) begin
                done_edge = e;
                start = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (mem_addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_ctrl: addr=%0d busy=%b done=%b required 0/0/0", mem_addr, busy, done);
        end else pass_cnt++;
        for (int n = 0; n < M1; n++) begin
            total_cnt++;
            if (layer1_outputs[n] !== 26'sd0)
                $display("FAIL reset_out[%0d]: got %0d required 0", n, layer1_outputs[n]);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bias_only();
        int de;
        int exp_addr [5];
        exp_addr = '{M0, 0, M0 + M1, 1, M0 + M1 + 1};
        randomize_mem();
        for (int i = 0; i < M0; i++) mem[i] = 8'd0;
        for (int n = 0; n < M1; n++) mem[M0 + n] = 8'((n - 8) * 16);
        addr_log.delete();
        log_en = 1'b1;
        do_run(-1, de);
        log_en = 1'b0;
        total_cnt++;
        if (de !== RUN_EDGES) $display("FAIL bias_done_edge: got %0d required %0d", de, RUN_EDGES);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL bias_busy_at_done: got %b required 0", busy);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if (addr_log.size() <= k || int'(addr_log[k]) != exp_addr[k])
                $display("FAIL bias_addr_seq[%0d]: got %0d required %0d", k,
                         (addr_log.size() > k) ? int'(addr_log[k]) : -1, exp_addr[k]);
            else pass_cnt++;
        end
        for (int n = 0; n < M1; n++) begin
            total_cnt++;
            if (layer1_outputs[n] !== 26'(((n > 8) ? n - 8 : 0) * 4096))
                $display("FAIL bias_out[%0d]: got %0d required %0d", n, layer1_outputs[n],
                         ((n > 8) ? n - 8 : 0) * 4096);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_width: got %b required 0", done);
        else pass_cnt++;
    endtask

    task automatic test_extremes();
        int de;
        logic [7:0] wv [3];
        logic [7:0] bv [3];
        int req [3];
        wv  = '{8'h01, 8'h80, 8'h7F};
        bv  = '{8'h00, 8'h7F, 8'h7F};
        req = '{M0 * 127, 0, M0 * 16192 + 127 * 256};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < M0; i++) mem[i] = 8'hFF;
            for (int n = 0; n < M1; n++) mem[M0 + n] = bv[c];
            for (int a = 0; a < M1 * M0; a++) mem[M0 + M1 + a] = wv[c];
            @(negedge clk);
            do_run(-1, de);
            total_cnt++;
            if (de !== RUN_EDGES) $display("FAIL extreme%0d_done_edge: got %0d required %0d", c, de, RUN_EDGES);
            else pass_cnt++;
            for (int n = 0; n < M1; n++) begin
                total_cnt++;
                if (layer1_outputs[n] !== 26'(req[c]))
                    $display("FAIL extreme%0d_out[%0d]: got %0d required %0d", c, n, layer1_outputs[n], req[c]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        int de;
        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            compute_model();
            @(negedge clk);
            do_run(-1, de);
            total_cnt++;
            if (de !== RUN_EDGES) $display("FAIL random%0d_done_edge: got %0d required %0d", r, de, RUN_EDGES);
            else pass_cnt++;
            for (int n = 0; n < M1; n++) begin
                total_cnt++;
                if (layer1_outputs[n] !== 26'(exp_out[n]))
                    $display("FAIL random%0d_out[%0d]: got %0d required %0d", r, n, layer1_outputs[n], exp_out[n]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_start_ignored();
        int de;
        int extra;
        randomize_mem();
        compute_model();
        @(negedge clk);
        do_run(100, de);
        total_cnt++;
        if (de !== RUN_EDGES) $display("FAIL held_start_done_edge: got %0d required %0d", de, RUN_EDGES);
        else pass_cnt++;
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        total_cnt++;
        if (extra != 0) $display("FAIL held_start_extra_activity: got %0d cycles required 0", extra);
        else pass_cnt++;
        for (int n = 0; n < M1; n++) begin
            total_cnt++;
            if (layer1_outputs[n] !== 26'(exp_out[n]))
                $display("FAIL held_start_out[%0d]: got %0d required %0d", n, layer1_outputs[n], exp_out[n]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int de;
        randomize_mem();
        compute_model();
        @(negedge clk);
        do_run(-1, de);
        total_cnt++;
        if (de !== RUN_EDGES) $display("FAIL b2b_first_done_edge: got %0d required %0d", de, RUN_EDGES);
        else pass_cnt++;
        // New weights, then start lands in the cycle right after DONE.
        for (int a = 0; a < M1 * M0; a++) mem[M0 + M1 + a] = 8'($urandom);
        compute_model();
        do_run(-1, de);
        total_cnt++;
        if (de !== RUN_EDGES) $display("FAIL b2b_second_done_edge: got %0d required %0d", de, RUN_EDGES);
        else pass_cnt++;
        for (int n = 0; n < M1; n++) begin
            total_cnt++;
            if (layer1_outputs[n] !== 26'(exp_out[n]))
                $display("FAIL b2b_out[%0d]: got %0d required %0d", n, layer1_outputs[n], exp_out[n]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_run();
        int de;
        int stray;
        randomize_mem();
        compute_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5 * (6 * M0 + 4) + 10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0 || mem_addr !== '0 || done !== 1'b0)
            $display("FAIL midrst_ctrl: busy=%b addr=%0d done=%b required 0/0/0", busy, mem_addr, done);
        else pass_cnt++;
        stray = 0;
        for (int n = 0; n < M1; n++) if (layer1_outputs[n] !== 26'sd0) stray++;
        total_cnt++;
        if (stray != 0) $display("FAIL midrst_outputs: got %0d nonzero required 0", stray);
        else pass_cnt++;
        rst = 1'b0;
        stray = 0;
        repeat (RUN_EDGES) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        total_cnt++;
        if (stray != 0) $display("FAIL midrst_no_done: got %0d active cycles required 0", stray);
        else pass_cnt++;
        do_run(-1, de);
        total_cnt++;
        if (de !== RUN_EDGES) $display("FAIL midrst_rerun_done_edge: got %0d required %0d", de, RUN_EDGES);
        else pass_cnt++;
        for (int n = 0; n < M1; n++) begin
            total_cnt++;
            if (layer1_outputs[n] !== 26'(exp_out[n]))
                $display("FAIL midrst_out[%0d]: got %0d required %0d", n, layer1_outputs[n], exp_out[n]);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        log_en    = 1'b0;
        prev_addr = '0;
        rst       = 1'b1;
        start     = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'd0;
        test_reset();
        test_bias_only();
        test_extremes();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
